// File: rtl/relu_stream_layer.sv
// Two-stage valid/ready activation stage: per-beat ReLU, leaky ReLU or clipped ReLU across
// CHANNELS packed signed values, with saturating counters of zeroed and clipped channels.
module relu_stream_layer #(
  parameter int unsigned I_WIDTH    = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CLIP_MAX   = 127,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [I_WIDTH*CHANNELS-1:0]   input_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [I_WIDTH*CHANNELS-1:0]   output_data,
  input  logic                          stat_clear,
  output logic [STAT_WIDTH-1:0]         zero_count,
  output logic [STAT_WIDTH-1:0]         clip_count
);

  localparam int unsigned DW  = I_WIDTH * CHANNELS;
  localparam int unsigned CW  = $clog2(CHANNELS + 1);
  localparam int unsigned SW1 = STAT_WIDTH + 1;
  localparam logic [1:0]  MODE_LEAKY = 2'd1;
  localparam logic [1:0]  MODE_CLIP  = 2'd2;
  localparam logic signed [I_WIDTH-1:0] CLIP_V = I_WIDTH'(CLIP_MAX);

  logic                  s1_valid_q, s1_valid_d;
  logic [DW-1:0]         s1_data_q,  s1_data_d;
  logic [1:0]            s1_mode_q,  s1_mode_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DW-1:0]         s2_data_q,  s2_data_d;
  logic [STAT_WIDTH-1:0] zero_q,     zero_d;
  logic [STAT_WIDTH-1:0] clip_q,     clip_d;

  logic                  adv1_c, adv2_c, accept_c, move_c;
  logic [DW-1:0]         act_c;
  logic [CW-1:0]         zero_inc_c, clip_inc_c;
  logic [SW1-1:0]        zero_sum_c, clip_sum_c;

  // A stage may load when it is empty or its contents move on this edge.
  assign adv2_c   = !s2_valid_q | out_ready;
  assign adv1_c   = !s1_valid_q | adv2_c;
  assign in_ready = adv1_c & !reset;
  assign accept_c = in_valid & in_ready;
  assign move_c   = s1_valid_q & adv2_c;

  assign out_valid   = s2_valid_q;
  assign output_data = s2_data_q;
  assign zero_count  = zero_q;
  assign clip_count  = clip_q;

  // Per-channel activation of the S1 beat plus its statistics contribution.
  always_comb begin
    act_c      = '0;
    zero_inc_c = '0;
    clip_inc_c = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      logic signed [I_WIDTH-1:0] x;
      logic signed [I_WIDTH-1:0] y;
      x = s1_data_q[c*I_WIDTH +: I_WIDTH];
      y = x;
      if (x[I_WIDTH-1]) begin
        if (s1_mode_q == MODE_LEAKY) begin
          y = x >>> LEAK_SHIFT;
        end else begin
          y          = '0;
          zero_inc_c = zero_inc_c + CW'(1);
        end
      end else if ((s1_mode_q == MODE_CLIP) && (x > CLIP_V)) begin
        y          = CLIP_V;
        clip_inc_c = clip_inc_c + CW'(1);
      end
      act_c[c*I_WIDTH +: I_WIDTH] = y;
    end
  end

  // Pipeline advance and saturating counters; clear beats a same-edge increment.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    zero_d     = zero_q;
    clip_d     = clip_q;
    zero_sum_c = SW1'(zero_q) + SW1'(zero_inc_c);
    clip_sum_c = SW1'(clip_q) + SW1'(clip_inc_c);

    if (adv1_c) s1_valid_d = accept_c;
    if (accept_c) begin
      s1_data_d = input_data;
      s1_mode_d = mode;
    end
    if (adv2_c) s2_valid_d = s1_valid_q;
    if (move_c) s2_data_d = act_c;

    if (stat_clear) begin
      zero_d = '0;
      clip_d = '0;
    end else if (move_c) begin
      zero_d = zero_sum_c[STAT_WIDTH] ? '1 : zero_sum_c[STAT_WIDTH-1:0];
      clip_d = clip_sum_c[STAT_WIDTH] ? '1 : clip_sum_c[STAT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      zero_q     <= '0;
      clip_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      zero_q     <= zero_d;
      clip_q     <= clip_d;
    end
  end

endmodule

// File: tb/tb_relu_stream_layer.sv
// Scoreboard bench for relu_stream_layer: directed cases, backpressure, reset flush,
// counter saturation (second instance with 2-bit counters) and a randomized stream.
module tb_relu_stream_layer;

  localparam int unsigned W    = 8;
  localparam int unsigned CH   = 3;
  localparam int unsigned DW   = W * CH;
  localparam int unsigned SH   = 3;
  localparam int          CLIP = 6;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready, stat_clear;
  logic [1:0]    mode;
  logic [DW-1:0] input_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] output_data;
  logic [15:0]   zero_count, clip_count;
  logic          in_ready2, out_valid2;
  logic [DW-1:0] output_data2;
  logic [1:0]    zero_count2, clip_count2;

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] sb[$];
  int exp_z, exp_c, exp_z2, exp_c2;
  logic          hold;
  logic [DW-1:0] held;

  always #5 clk = ~clk;

  relu_stream_layer #(.I_WIDTH(W), .CHANNELS(CH), .LEAK_SHIFT(SH), .CLIP_MAX(CLIP), .STAT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .input_data(input_data), .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
    .stat_clear(stat_clear), .zero_count(zero_count), .clip_count(clip_count));

  relu_stream_layer #(.I_WIDTH(W), .CHANNELS(CH), .LEAK_SHIFT(SH), .CLIP_MAX(CLIP), .STAT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready2),
    .input_data(input_data), .out_valid(out_valid2), .out_ready(out_ready), .output_data(output_data2),
    .stat_clear(stat_clear), .zero_count(zero_count2), .clip_count(clip_count2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] r;
    logic [W-1:0]  b;
    int x, v;
    r = '0;
    for (int c = 0; c < int'(CH); c++) begin
      b = d[c*W +: W];
      x = int'($signed(b));
      if (x < 0) v = (m == 2'd1) ? (x - ((1 << SH) - 1)) / (1 << SH) : 0;
      else if (m == 2'd2 && x > CLIP) v = CLIP;
      else v = x;
      r[c*W +: W] = W'(v);
    end
    return r;
  endfunction

  function automatic int sat(input int a, input int b, input int mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic [DW-1:0] e);
    int n = 0;
    int nz = 0;
    int nc = 0;
    logic acc;
    logic [W-1:0] b;
    in_valid = 1'b1; input_data = d; mode = m;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    check("accept", 32'(acc), 32'd1);
    if (acc) begin
      sb.push_back(e);
      for (int c = 0; c < int'(CH); c++) begin
        b = d[c*W +: W];
        if ($signed(b) < 0 && m != 2'd1) nz++;
        if (m == 2'd2 && $signed(b) > CLIP) nc++;
      end
      exp_z = sat(exp_z, nz, 65535); exp_c = sat(exp_c, nc, 65535);
      exp_z2 = sat(exp_z2, nz, 3);   exp_c2 = sat(exp_c2, nc, 3);
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    if (reset) begin
      hold <= 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(output_data), 32'(held));
      end
      if (out_valid) check("dut2_mirror", {6'd0, in_ready2, out_valid2, output_data2},
                           {6'd0, in_ready, out_valid, output_data});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_beat", 32'(out_valid), 32'd0);
        else check("out_data", 32'(output_data), 32'(sb.pop_front()));
      end
      hold <= out_valid && !out_ready;
      held <= output_data;
    end
  end

  initial begin
    #400000;
    check("watchdog", 32'd0, 32'd1);
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    m;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clear = 1'b0;
    mode = 2'd0; input_data = '0;
    exp_z = 0; exp_c = 0; exp_z2 = 0; exp_c2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(output_data), 32'd0);
    check("rst_zero", 32'(zero_count), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // ReLU with latency check
    send(24'h807FFF, 2'd0, 24'h007F00);
    in_valid = 1'b0;
    check("lat_s1_only", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_s2_valid", 32'(out_valid), 32'd1);
    check("lat_s2_data", 32'(output_data), 32'h007F00);
    drain();
    check("t1_zero", 32'(zero_count), 32'd2);
    check("t1_clip", 32'(clip_count), 32'd0);

    // Leaky
    send(24'hF001FF, 2'd1, 24'hFE01FF);
    in_valid = 1'b0;
    drain();
    check("t2_zero", 32'(zero_count), 32'd2);
    check("t2_clip", 32'(clip_count), 32'd0);

    // Clipped
    send(24'h050790, 2'd2, 24'h050600);
    in_valid = 1'b0;
    drain();
    check("t3_zero", 32'(zero_count), 32'd3);
    check("t3_clip", 32'(clip_count), 32'd1);
    check("t3_zero_sat2", 32'(zero_count2), 32'd3);

    // Backpressure: out_ready low for 3 cycles while beats 1..6 stream in
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          d = {W'(i), W'(i + 1), W'(i)};
          send(d, 2'd0, d);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight flushes them and the counters
    out_ready = 1'b0;
    send(24'h808080, 2'd0, 24'h000000);
    send(24'h818181, 2'd0, 24'h000000);
    in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    exp_z = 0; exp_c = 0; exp_z2 = 0; exp_c2 = 0;
    @(posedge clk); #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_zero", 32'(zero_count), 32'd0);
    check("flush_clip", 32'(clip_count), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_output", 32'(out_valid), 32'd0);
    send(24'h017F05, 2'd2, 24'h010605);
    in_valid = 1'b0;
    check("post_rst_lat_s1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("post_rst_lat_s2", 32'(out_valid), 32'd1);
    drain();

    // Saturation on 2-bit counters, then clear vs same-edge increment
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    exp_z = 0; exp_c = 0; exp_z2 = 0; exp_c2 = 0;
    check("clr_zero", 32'(zero_count), 32'd0);
    check("clr_clip", 32'(clip_count), 32'd0);
    send(24'h808001, 2'd0, 24'h000001);
    send(24'h80FF01, 2'd3, 24'h000001);
    in_valid = 1'b0;
    drain();
    check("sat_zero16", 32'(zero_count), 32'd4);
    check("sat_zero2", 32'(zero_count2), 32'd3);
    send(24'h808080, 2'd0, 24'h000000);
    stat_clear = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    check("clr_prio_zero", 32'(zero_count), 32'd0);
    check("clr_prio_zero2", 32'(zero_count2), 32'd0);
    drain();
    check("clr_prio_hold", 32'(zero_count), 32'd0);
    exp_z = 0; exp_c = 0; exp_z2 = 0; exp_c2 = 0;

    // Randomized stream, per-beat mode changes, random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          d = DW'($urandom);
          m = 2'($urandom_range(0, 3));
          send(d, m, model(d, m));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        in_valid = 1'b0;
      end
      begin
        repeat (120) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rnd_zero", 32'(zero_count), 32'(exp_z));
    check("rnd_clip", 32'(clip_count), 32'(exp_c));
    check("rnd_zero2", 32'(zero_count2), 32'(exp_z2));
    check("rnd_clip2", 32'(clip_count2), 32'(exp_c2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
